// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B one accepted bit per cycle, LSB first,
// over a WIDTH-bit frame, with per-bit output plus parallel word and final borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             valid_in,
  input  logic             a_in,
  input  logic             b_in,
  output logic             diff_out,
  output logic             diff_valid_out,
  output logic [WIDTH-1:0] diff_word_out,
  output logic             borrow_out,
  output logic             done_out,
  output logic             busy_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             borrow_r, borrow_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic             diff_s, diff_valid_s, done_s, busy_s, borrow_out_s;
  logic [WIDTH-1:0] word_s;

  function automatic logic diff_bit(input logic a, input logic b, input logic br);
    diff_bit = a ^ b ^ br;
  endfunction

  function automatic logic borrow_next(input logic a, input logic b, input logic br);
    borrow_next = (~a & b) | (~(a ^ b) & br);
  endfunction

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    borrow_s     = borrow_r;
    shift_s      = shift_r;
    diff_s       = diff_out;
    diff_valid_s = 1'b0;
    word_s       = diff_word_out;
    borrow_out_s = borrow_out;
    done_s       = (state_r == DONE);

    case (state_r)
      IDLE: begin
        if (start_in) begin
          state_s      = RUN;
          cnt_s        = '0;
          borrow_s     = 1'b0;
          shift_s      = '0;
          word_s       = '0;
          borrow_out_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (start_in) begin
          // Abort: restart the frame with the same clear as from IDLE.
          state_s      = RUN;
          cnt_s        = '0;
          borrow_s     = 1'b0;
          shift_s      = '0;
          word_s       = '0;
          borrow_out_s = 1'b0;
        end else if (valid_in) begin
          diff_s       = diff_bit(a_in, b_in, borrow_r);
          diff_valid_s = 1'b1;
          borrow_s     = borrow_next(a_in, b_in, borrow_r);
          shift_s      = {diff_bit(a_in, b_in, borrow_r), shift_r[WIDTH-1:1]};
          cnt_s        = (cnt_r == CW'(WIDTH)) ? cnt_r : cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        // The completed result is published alongside done_out even if a
        // new frame starts in the same cycle.
        word_s       = shift_r;
        borrow_out_s = borrow_r;
        if (start_in) begin
          state_s  = RUN;
          cnt_s    = '0;
          borrow_s = 1'b0;
          shift_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s == RUN);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      borrow_r       <= 1'b0;
      shift_r        <= '0;
      diff_out       <= 1'b0;
      diff_valid_out <= 1'b0;
      diff_word_out  <= '0;
      borrow_out     <= 1'b0;
      done_out       <= 1'b0;
      busy_out       <= 1'b0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      borrow_r       <= borrow_s;
      shift_r        <= shift_s;
      diff_out       <= diff_s;
      diff_valid_out <= diff_valid_s;
      diff_word_out  <= word_s;
      borrow_out     <= borrow_out_s;
      done_out       <= done_s;
      busy_out       <= busy_s;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a WIDTH=4 and a WIDTH=8 instance,
// table vectors, random frames against an arithmetic model, and corner sequences.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       s4_start = 1'b0, s4_valid = 1'b0, s4_a = 1'b0, s4_b = 1'b0;
  logic       s8_start = 1'b0, s8_valid = 1'b0, s8_a = 1'b0, s8_b = 1'b0;
  logic       d4_diff, d4_dv, d4_borrow, d4_done, d4_busy;
  logic [3:0] d4_word;
  logic       d8_diff, d8_dv, d8_borrow, d8_done, d8_busy;
  logic [7:0] d8_word;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk_in(clk), .rst_in(rst), .start_in(s4_start), .valid_in(s4_valid),
    .a_in(s4_a), .b_in(s4_b), .diff_out(d4_diff), .diff_valid_out(d4_dv),
    .diff_word_out(d4_word), .borrow_out(d4_borrow), .done_out(d4_done),
    .busy_out(d4_busy)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk_in(clk), .rst_in(rst), .start_in(s8_start), .valid_in(s8_valid),
    .a_in(s8_a), .b_in(s8_b), .diff_out(d8_diff), .diff_valid_out(d8_dv),
    .diff_word_out(d8_word), .borrow_out(d8_borrow), .done_out(d8_done),
    .busy_out(d8_busy)
  );

  int checks = 0;
  int failures = 0;

  logic       o_diff, o_dv, o_borrow, o_done, o_busy;
  logic [7:0] o_word;

  typedef struct {
    int         sel;
    logic [7:0] a;
    logic [7:0] b;
    int         mode;
    logic [7:0] exp_word;
    logic       exp_borrow;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sample(input int sel);
    if (sel == 0) begin
      o_diff = d4_diff; o_dv = d4_dv; o_borrow = d4_borrow;
      o_done = d4_done; o_busy = d4_busy; o_word = {4'b0000, d4_word};
    end else begin
      o_diff = d8_diff; o_dv = d8_dv; o_borrow = d8_borrow;
      o_done = d8_done; o_busy = d8_busy; o_word = d8_word;
    end
  endtask

  // Drive one cycle of inputs to the selected instance, then sample just after the edge.
  task automatic cycle(input int sel, input logic st, input logic v, input logic a, input logic b);
    s4_start = (sel == 0) && st; s4_valid = (sel == 0) && v;
    s4_a = (sel == 0) && a;      s4_b = (sel == 0) && b;
    s8_start = (sel == 1) && st; s8_valid = (sel == 1) && v;
    s8_a = (sel == 1) && a;      s8_b = (sel == 1) && b;
    @(posedge clk);
    #1;
    sample(sel);
  endtask

  // mode: 0 continuous valid, 1 valid every other cycle, 2 random valid
  task automatic run_frame(input int sel, input logic [7:0] a, input logic [7:0] b,
                           input int mode, input logic [7:0] exp_word,
                           input logic exp_borrow, input string tag);
    int         w;
    int         nbits, ndv, t, last_dv, acc_last, done_at, ndone, dv_err, busy_cnt;
    logic       v;
    logic [7:0] got_bits, word_at_done;
    logic       borrow_at_done;
    w = (sel == 0) ? 4 : 8;
    nbits = 0; ndv = 0; t = 0; last_dv = -1; acc_last = -1; done_at = -1;
    ndone = 0; dv_err = 0; busy_cnt = 0; got_bits = 8'h00;
    word_at_done = 8'h00; borrow_at_done = 1'b0;

    // Bits presented on the start cycle must be ignored.
    cycle(sel, 1'b1, 1'b1, 1'b1, 1'b0);
    check({tag, " start"}, {o_busy, o_dv, o_done, o_borrow, o_word}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    if (o_busy) busy_cnt++;

    while (nbits < w && t < 100) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = t[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      cycle(sel, 1'b0, v, a[nbits], b[nbits]);
      if (v) begin
        nbits++;
        acc_last = t;
      end
      if (o_dv !== v) dv_err++;
      if (o_dv === 1'b1) begin
        if (ndv < 8) got_bits[ndv] = o_diff;
        ndv++;
        last_dv = t;
      end
      if (o_busy) busy_cnt++;
      if (o_done) begin ndone++; done_at = t; end
      t++;
    end
    if (nbits < w) check({tag, " feed timeout"}, nbits, w);

    // Trailing cycles: valid_in is asserted but must be ignored in DONE/IDLE.
    for (int k = 0; k < 4; k++) begin
      cycle(sel, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (o_dv !== 1'b0) dv_err++;
      if (o_dv === 1'b1) ndv++;
      if (o_busy) busy_cnt++;
      if (o_done) begin ndone++; done_at = t; end
      if (k == 0) begin word_at_done = o_word; borrow_at_done = o_borrow; end
      t++;
    end

    check({tag, " dv pattern errors"}, dv_err, 0);
    check({tag, " dv pulse count"}, ndv, w);
    check({tag, " serial bits"}, got_bits, exp_word);
    check({tag, " done count"}, ndone, 1);
    check({tag, " done timing"}, done_at, last_dv + 1);
    check({tag, " busy cycles"}, busy_cnt, acc_last + 1);
    check({tag, " word at done"}, word_at_done, exp_word);
    check({tag, " borrow at done"}, borrow_at_done, exp_borrow);
    check({tag, " word held"}, o_word, exp_word);
    check({tag, " borrow held"}, o_borrow, exp_borrow);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [3:0] pa, pb;
    int         nd;
    int         sel, mode;
    logic [7:0] ra, rb, mask, ew;
    logic [8:0] dif;
    logic       eb;

    vecs[0] = '{0, 8'h05, 8'h03, 0, 8'h02, 1'b0};
    vecs[1] = '{0, 8'h03, 8'h05, 0, 8'h0E, 1'b1};
    vecs[2] = '{1, 8'h00, 8'h01, 1, 8'hFF, 1'b1};
    vecs[3] = '{0, 8'h09, 8'h09, 2, 8'h00, 1'b0};
    vecs[4] = '{1, 8'hA5, 8'h5A, 2, 8'h4B, 1'b0};
    vecs[5] = '{1, 8'h10, 8'h20, 0, 8'hF0, 1'b1};
    vecs[6] = '{0, 8'h0F, 8'h00, 1, 8'h0F, 1'b0};
    vecs[7] = '{0, 8'h00, 8'h0F, 2, 8'h01, 1'b1};

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    sample(0);
    check("reset outputs w4", {o_diff, o_dv, o_borrow, o_done, o_busy, o_word}, 13'h0);
    sample(1);
    check("reset outputs w8", {o_diff, o_dv, o_borrow, o_done, o_busy, o_word}, 13'h0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].mode,
                vecs[i].exp_word, vecs[i].exp_borrow, $sformatf("vec%0d", i));
    end

    // Restart mid-frame: two bits, then a fresh start with A=9, B=9.
    nd = 0;
    cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b1, 1'b0);
    if (o_done) nd++;
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b1);
    if (o_done) nd++;
    check("restart aborted done", nd, 0);
    run_frame(0, 8'h09, 8'h09, 0, 8'h00, 1'b0, "restart");

    // Reset mid-frame after three bits, then a clean frame A=7, B=2.
    cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("midreset busy before", o_busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    sample(0);
    check("midreset outputs", {o_diff, o_dv, o_borrow, o_done, o_busy, o_word}, 13'h0);
    #2;
    rst = 1'b0;
    run_frame(0, 8'h07, 8'h02, 0, 8'h05, 1'b0, "after reset");

    // Start during DONE: done still pulses with 6-1, then 2-3 runs immediately.
    pa = 4'd6; pb = 4'd1;
    cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(0, 1'b0, 1'b1, pa[i], pb[i]);
    cycle(0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("start in done", {o_done, o_busy, o_dv, o_borrow, o_word}, {1'b1, 1'b1, 1'b0, 1'b0, 8'h05});
    pa = 4'd2; pb = 4'd3;
    for (int i = 0; i < 4; i++) cycle(0, 1'b0, 1'b1, pa[i], pb[i]);
    check("done after chained start", o_done, 1'b0);
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("chained frame result", {o_done, o_borrow, o_word}, {1'b1, 1'b1, 8'h0F});

    // Random frames against the arithmetic model.
    for (int n = 0; n < 24; n++) begin
      sel  = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 2));
      mask = (sel == 0) ? 8'h0F : 8'hFF;
      ra   = 8'($urandom) & mask;
      rb   = 8'($urandom) & mask;
      dif  = {1'b0, ra} - {1'b0, rb};
      ew   = dif[7:0] & mask;
      eb   = (ra < rb);
      run_frame(sel, ra, rb, mode, ew, eb, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes A − B one bit per accepted cycle, LSB first, over a WIDTH-bit frame.
- Uses a registered borrow chain, a bit counter and a small FSM.
- Counterpart to the combinational half-adder arithmetic block: it performs the inverse operation, sequentially, for operands arriving on serial links.
- Emits each difference bit as it is computed, plus the assembled parallel word and final borrow at end of frame.

Parameters:
- WIDTH, 8, operand/frame length in bits (≥2).

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- start_in  input  1  begin new frame; sampled only on a rising edge.
- valid_in  input  1  a_in/b_in carry a valid bit this cycle.
- a_in  input  1  minuend bit, LSB first.
- b_in  input  1  subtrahend bit, LSB first.
- diff_out  output  1  registered difference bit.
- diff_valid_out  output  1  diff_out valid (1-cycle pulse per accepted bit).
- diff_word_out  output  WIDTH  assembled difference; stable from done_out until next start.
- borrow_out  output  1  final borrow (1 ⇒ A < B unsigned); updated with done_out.
- done_out  output  1  1-cycle pulse: frame complete.
- busy_out  output  1  high while in RUN.

Behaviour:
- Reset (async, rst_in=1): FSM→IDLE; counter=0; internal borrow=0; all outputs 0, including diff_word_out.
- FSM states:
  - IDLE: start_in=1 → RUN; clear borrow, counter and the shift register. Bits on the start cycle are ignored.
  - RUN: each cycle with valid_in=1 accepts one bit:
    - d = a ^ b ^ br
    - br_next = (~a & b) | (~(a ^ b) & br)
    - The counter increments.
    - d shifts into diff_word_out from the MSB side, so after WIDTH bits bit 0 = first bit.
    - If valid_in=0, nothing changes (stall) and diff_valid_out=0.
  - When the WIDTH-th bit is accepted: go to DONE.
  - DONE (one cycle): done_out=1, borrow_out=final br, then → IDLE.
- Output timing and latency:
  - diff_out and diff_valid_out are registered: they appear the cycle after the bit is accepted (latency 1).
  - done_out asserts the cycle after the last diff_valid_out.
- busy_out = 1 in RUN only.
- start_in during RUN: abort the current frame and restart (same clear as from IDLE). No done_out for the aborted frame; diff_valid_out=0 on the restart cycle.
- start_in during DONE: done_out still pulses, and the FSM goes directly to RUN with the clear applied.
- valid_in in IDLE/DONE: ignored.
- borrow_out and diff_word_out hold their last frame's values until the next DONE. They clear only on reset or on start.
- rst_in mid-frame: immediate return to reset state; the partial result is discarded.
- Counter width: clog2(WIDTH+1). No wrap: the counter saturates at WIDTH and is reset on start.

Test Plan:
- Reset check: assert rst_in asynchronously between clock edges → all outputs 0 immediately; busy_out=0.
- WIDTH=4, A=5 (1010 LSB-first), B=3 (1100 LSB-first), valid_in continuous → diff bits 0,1,0,0; diff_word_out=4'b0010; borrow_out=0; done_out one pulse 1 cycle after last diff_valid_out.
- WIDTH=4, A=3, B=5 → diff_word_out=4'b1110, borrow_out=1.
- WIDTH=8, A=8'h00, B=8'h01, valid_in toggling 1/0 every cycle → 8 diff_valid_out pulses only; diff_word_out=8'hFF; borrow_out=1; frame takes 16 cycles of RUN.
- Restart: start, feed 2 bits, assert start_in again, then feed A=9, B=9 (WIDTH=4) → exactly one done_out; diff_word_out=4'b0000; borrow_out=0.
- Reset mid-frame: after 3 bits assert rst_in → outputs 0 and IDLE; a new frame A=7, B=2 then yields 4'b0101, borrow_out=0.
